// File: rtl/ball_render_pkg.sv
// Shared types and register-map constants for the GravSim ball renderer.
// Field offsets are helpers so the top can scale with coordinate width.
package ball_render_pkg;

    localparam int X_LSB             = 0;
    localparam int EN_BIT            = 31;
    localparam int STATUS_BIT_COMMIT = 0;
    localparam int FRAME_COUNT_LSB   = 8;
    localparam int FRAME_COUNT_W     = 8;

    function automatic int y_lsb(input int coord_w);
        return coord_w;
    endfunction

    function automatic int r_lsb(input int coord_w);
        return 2 * coord_w;
    endfunction

    // Register image for the default 10-bit coordinate / 6-bit radius build.
    typedef struct packed {
        logic       enable;
        logic [4:0] rsvd;
        logic [5:0] radius;
        logic [9:0] y;
        logic [9:0] x;
    } ball_t;

endpackage

// File: rtl/ball_hit_unit.sv
// One ball's hit test: stage 1 registers dx/dy, the squared-distance
// compare is combinational and registered by the priority stage in the top.
module ball_hit_unit #(
    parameter int COORD_W  = 10,
    parameter int RADIUS_W = 6
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [COORD_W-1:0]  draw_x_i,
    input  logic [COORD_W-1:0]  draw_y_i,
    input  logic [COORD_W-1:0]  ball_x_i,
    input  logic [COORD_W-1:0]  ball_y_i,
    input  logic [RADIUS_W-1:0] radius_i,
    input  logic                enable_i,
    output logic                hit_o
);

    localparam int SW = 2 * COORD_W + 3;

    logic [COORD_W:0]  dx_d, dy_d, dx_q, dy_q;
    logic [RADIUS_W-1:0] r_q;
    logic              en_q;
    logic [COORD_W:0]  adx, ady;
    logic [SW-1:0]     dist_sq, rad_sq;

    assign dx_d = {1'b0, draw_x_i} - {1'b0, ball_x_i};
    assign dy_d = {1'b0, draw_y_i} - {1'b0, ball_y_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dx_q <= '0;
            dy_q <= '0;
            r_q  <= '0;
            en_q <= 1'b0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
            r_q  <= radius_i;
            en_q <= enable_i;
        end
    end

    // Magnitude of a (COORD_W+1)-bit two's complement value fits unsigned.
    assign adx = dx_q[COORD_W] ? -dx_q : dx_q;
    assign ady = dy_q[COORD_W] ? -dy_q : dy_q;

    assign dist_sq = SW'(adx) * SW'(adx) + SW'(ady) * SW'(ady);
    assign rad_sq  = SW'(r_q) * SW'(r_q);

    assign hit_o = en_q && (dist_sq <= rad_sq);

endmodule

// File: rtl/ball_render_engine.sv
// Avalon-programmed ball renderer: pending/active register sets committed
// on VGA_VS falling edge, per-pixel hit test with lowest-index priority.
module ball_render_engine
    import ball_render_pkg::*;
#(
    parameter int NUM_BALLS = 4,
    parameter int COORD_W   = 10,
    parameter int RADIUS_W  = 6,
    parameter int ID_W      = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1,
    parameter int ADDR_W    = $clog2(NUM_BALLS + 1)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    input  logic              VGA_VS,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    output logic              is_ball,
    output logic [ID_W-1:0]   ballID
);

    localparam int Y_LSB  = y_lsb(COORD_W);
    localparam int R_LSB  = r_lsb(COORD_W);
    localparam int FLD_HI = R_LSB + RADIUS_W;
    localparam logic [31:0] BALL_MASK =
        ((32'd1 << FLD_HI) - 32'd1) | (32'd1 << EN_BIT);
    localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(NUM_BALLS);

    logic [31:0]         pend_q  [NUM_BALLS];
    logic [COORD_W-1:0]  act_x_q [NUM_BALLS];
    logic [COORD_W-1:0]  act_y_q [NUM_BALLS];
    logic [RADIUS_W-1:0] act_r_q [NUM_BALLS];
    logic [NUM_BALLS-1:0] act_en_q;

    logic                     commit_req_q;
    logic [FRAME_COUNT_W-1:0] frame_q;
    logic                     vs_q;
    logic [31:0]              rdata_d, rdata_q;
    logic [NUM_BALLS-1:0]     hit;
    logic                     is_ball_d, is_ball_q;
    logic [ID_W-1:0]          id_d, id_q;
    logic                     commit_evt;
    logic                     req_set;

    assign commit_evt = vs_q && !VGA_VS && commit_req_q;
    assign req_set    = avs_write && (avs_address == STATUS_ADDR)
                        && avs_writedata[STATUS_BIT_COMMIT];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < NUM_BALLS; k++) begin
                pend_q[k]  <= '0;
                act_x_q[k] <= '0;
                act_y_q[k] <= '0;
                act_r_q[k] <= '0;
            end
            act_en_q     <= '0;
            commit_req_q <= 1'b0;
            frame_q      <= '0;
            vs_q         <= 1'b1;
            rdata_q      <= '0;
            is_ball_q    <= 1'b0;
            id_q         <= '0;
        end else begin
            vs_q <= VGA_VS;
            // Copy sees pre-write pending; a same-cycle write lands after.
            if (commit_evt) begin
                for (int k = 0; k < NUM_BALLS; k++) begin
                    act_x_q[k]  <= pend_q[k][X_LSB +: COORD_W];
                    act_y_q[k]  <= pend_q[k][Y_LSB +: COORD_W];
                    act_r_q[k]  <= pend_q[k][R_LSB +: RADIUS_W];
                    act_en_q[k] <= pend_q[k][EN_BIT];
                end
                frame_q <= frame_q + 8'd1;
            end
            if (req_set)
                commit_req_q <= 1'b1;
            else if (commit_evt)
                commit_req_q <= 1'b0;
            for (int k = 0; k < NUM_BALLS; k++) begin
                if (avs_write && avs_address == ADDR_W'(k))
                    pend_q[k] <= avs_writedata & BALL_MASK;
            end
            if (avs_read)
                rdata_q <= rdata_d;
            is_ball_q <= is_ball_d;
            id_q      <= id_d;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (avs_address == STATUS_ADDR) begin
            rdata_d[STATUS_BIT_COMMIT] = commit_req_q;
            rdata_d[FRAME_COUNT_LSB +: FRAME_COUNT_W] = frame_q;
        end
        for (int k = 0; k < NUM_BALLS; k++) begin
            if (avs_address == ADDR_W'(k))
                rdata_d = pend_q[k];
        end
    end

    for (genvar g = 0; g < NUM_BALLS; g++) begin : g_hit
        ball_hit_unit #(
            .COORD_W  (COORD_W),
            .RADIUS_W (RADIUS_W)
        ) u_hit (
            .clk_i    (Clk),
            .rst_i    (Reset),
            .draw_x_i (DrawX),
            .draw_y_i (DrawY),
            .ball_x_i (act_x_q[g]),
            .ball_y_i (act_y_q[g]),
            .radius_i (act_r_q[g]),
            .enable_i (act_en_q[g]),
            .hit_o    (hit[g])
        );
    end

    always_comb begin
        is_ball_d = 1'b0;
        id_d      = '0;
        for (int k = NUM_BALLS - 1; k >= 0; k--) begin
            if (hit[k]) begin
                is_ball_d = 1'b1;
                id_d      = ID_W'(k);
            end
        end
    end

    assign avs_readdata = rdata_q;
    assign is_ball      = is_ball_q;
    assign ballID       = id_q;

endmodule
